// File: rtl/lane_traffic_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lane_traffic_ctrl                                            |
// | Description : Multi-lane car traffic generator. NUM_CARS cars, each locked |
// |               to a fixed lane Y, step in X on a shared prescaled game tick |
// |               with per-car direction and step divider, wrapping at edges.  |
// |               Optional macro CAR_LFSR_GAP_EN: a wrapping car hides for an  |
// |               LFSR-chosen number of ticks before reappearing.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lane_traffic_ctrl #(
  parameter int                    NUM_CARS      = 4,
  parameter int                    c_MAX_X       = 20,
  parameter int                    c_CAR_SPEED   = 1,
  parameter int                    c_SLOW_COUNT  = 4000000,
  parameter int                    COUNTER_WIDTH = 26,
  parameter logic [6*NUM_CARS-1:0] c_LANE_Y      = {6'd7, 6'd9, 6'd11, 6'd13},
  parameter logic [6*NUM_CARS-1:0] c_INIT_X      = {6'd15, 6'd10, 6'd5, 6'd0},
  parameter logic [NUM_CARS-1:0]   c_DIR_MASK    = 4'b1010,
  parameter logic [3*NUM_CARS-1:0] c_STEP_DIV    = {3'd0, 3'd1, 3'd2, 3'd3}
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Enable,
  input  logic                    i_Pause,
  input  logic [1:0]              i_Level,
  output logic [6*NUM_CARS-1:0]   o_Car_X,
  output logic [6*NUM_CARS-1:0]   o_Car_Y,
  output logic [NUM_CARS-1:0]     o_Car_Valid,
  output logic                    o_Tick
);

  localparam logic [5:0] c_SPEED6  = 6'(c_CAR_SPEED);
  localparam logic [5:0] c_WRAP_HI = 6'(c_MAX_X - c_CAR_SPEED);
  localparam logic [5:0] c_LAST_X  = 6'(c_MAX_X - 1);

  logic [COUNTER_WIDTH-1:0] prescaler;
  logic [31:0]              thr_raw;
  logic [31:0]              thr_m1;
  logic                     run;
  logic                     tick_fire;
  logic                     tick_q;

  // Tick threshold follows i_Level live; >= lets a lowered threshold fire at once
  always_comb begin
    thr_raw   = 32'(c_SLOW_COUNT) >> i_Level;
    thr_m1    = (thr_raw == 32'd0) ? 32'd0 : thr_raw - 32'd1;
    run       = i_Enable & ~i_Pause;
    tick_fire = run && (32'(prescaler) >= thr_m1);
  end

  // Prescaler and registered tick pulse; pause holds the count so no tick is lost
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      prescaler <= '0;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= tick_fire;
      if (!i_Enable) begin
        prescaler <= '0;
      end else if (tick_fire) begin
        prescaler <= '0;
      end else if (!i_Pause) begin
        prescaler <= prescaler + COUNTER_WIDTH'(1);
      end
    end
  end

  assign o_Tick = tick_q;
  assign o_Car_Y = c_LANE_Y;

`ifdef CAR_LFSR_GAP_EN
  typedef enum logic [0:0] {
    ST_ACTIVE = 1'b0,
    ST_HIDDEN = 1'b1
  } car_state_t;

  logic [7:0] lfsr;
  logic       lfsr_fb;

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // Gap-length LFSR, advanced once per game tick
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      lfsr <= 8'hA5;
    end else if (!i_Enable) begin
      lfsr <= 8'hA5;
    end else if (tick_fire) begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end
`else
  assign o_Car_Valid = '1;
`endif

  for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_car
    localparam logic [5:0] c_INIT    = c_INIT_X[6*gi +: 6];
    localparam logic [2:0] c_DIV     = c_STEP_DIV[3*gi +: 3];
    localparam logic       c_DIR_NEG = c_DIR_MASK[gi];

    logic [5:0] x_q;
    logic [5:0] x_next;
    logic [2:0] step_cnt;

    // Next X for one step, wrapping to the opposite edge
    always_comb begin
      x_next = x_q;
      if (c_DIR_NEG) begin
        x_next = (x_q < c_SPEED6) ? c_LAST_X : x_q - c_SPEED6;
      end else begin
        x_next = (x_q >= c_WRAP_HI) ? 6'd0 : x_q + c_SPEED6;
      end
    end

`ifdef CAR_LFSR_GAP_EN
    car_state_t state;
    logic [2:0] gap;
    logic       valid_q;
    logic       wraps;

    assign wraps = c_DIR_NEG ? (x_q < c_SPEED6) : (x_q >= c_WRAP_HI);

    // Per-car ACTIVE/HIDDEN FSM: a wrapping car hides for an LFSR-chosen gap
    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        state    <= ST_ACTIVE;
        x_q      <= c_INIT;
        step_cnt <= 3'd0;
        gap      <= 3'd0;
        valid_q  <= 1'b1;
      end else if (!i_Enable) begin
        state    <= ST_ACTIVE;
        x_q      <= c_INIT;
        step_cnt <= 3'd0;
        gap      <= 3'd0;
        valid_q  <= 1'b1;
      end else if (tick_fire) begin
        case (state)
          ST_HIDDEN: begin
            // The tick that counts the gap down to zero makes the car visible
            if (gap <= 3'd1) begin
              gap     <= 3'd0;
              state   <= ST_ACTIVE;
              valid_q <= 1'b1;
            end else begin
              gap <= gap - 3'd1;
            end
          end
          default: begin
            if (step_cnt == c_DIV) begin
              step_cnt <= 3'd0;
              x_q      <= x_next;
              if (wraps) begin
                state   <= ST_HIDDEN;
                valid_q <= 1'b0;
                gap     <= lfsr[2:0];
              end
            end else begin
              step_cnt <= step_cnt + 3'd1;
            end
          end
        endcase
      end
    end

    assign o_Car_Valid[gi] = valid_q;
`else
    // Per-car step divider and position update on each game tick
    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        x_q      <= c_INIT;
        step_cnt <= 3'd0;
      end else if (!i_Enable) begin
        x_q      <= c_INIT;
        step_cnt <= 3'd0;
      end else if (tick_fire) begin
        if (step_cnt == c_DIV) begin
          step_cnt <= 3'd0;
          x_q      <= x_next;
        end else begin
          step_cnt <= step_cnt + 3'd1;
        end
      end
    end
`endif

    assign o_Car_X[6*gi +: 6] = x_q;
  end

endmodule
`default_nettype wire
